pipe_adder: RTL and testbench

//  Parametrised S-stage pipelined ripple adder/subtractor with valid/ready handshake and backpressure.
//  N-bit operands are split into S carry segments; each carry is registered between stages.

---
 rtl/pipe_adder_pkg.sv | 37 +++
 rtl/adder_segment.sv | 45 ++++
 rtl/pipe_adder.sv | 148 ++++++++++++++
 tb/tb_pipe_adder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
//   Shared types and elaboration helpers for the pipelined adder/subtractor.
//   - seg_width(n, s)  : width of carry segments 0..s-2
//   - last_width(n, s) : width of the final (MSB) segment
//   - stage_ctl_t      : per-stage control register (valid bit + registered carry)
//   - full_adder()     : one-bit full adder cell used by adder_segment
// -----------------------------------------------------------------------------
package pipe_adder_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  typedef struct packed {
    logic sum;
    logic cout;
  } fa_t;

  function automatic int seg_width(input int n, input int s);
    return (n + s - 1) / s;
  endfunction

  // May come out < 1 for unusable (n, s) pairs; the top rejects those.
  function automatic int last_width(input int n, input int s);
    return n - (s - 1) * seg_width(n, s);
  endfunction

  function automatic fa_t full_adder(input logic a, input logic b, input logic cin);
    fa_t res;
    res.sum  = a ^ b ^ cin;
    res.cout = (a & b) | (cin & (a ^ b));
    return res;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// -----------------------------------------------------------------------------
// adder_segment
//   Combinational WS-bit ripple-carry adder built from full_adder cells.
//   Ports:
//     i_a, i_b  in  WS  segment operands
//     i_cin     in  1   carry into bit 0
//     o_sum     out WS  segment sum
//     o_cout    out 1   carry out of bit WS-1
//     o_cmsb    out 1   carry into bit WS-1 (for signed overflow at the MSB)
// -----------------------------------------------------------------------------
module adder_segment
  import pipe_adder_pkg::*;
#(
  parameter int WS = 4
) (
  input  logic [WS-1:0] i_a,
  input  logic [WS-1:0] i_b,
  input  logic          i_cin,
  output logic [WS-1:0] o_sum,
  output logic          o_cout,
  output logic          o_cmsb
);

  fa_t  w_fa;
  logic w_carry;

  // NOTE: every output and temporary gets a default at the top of the block,
  // so no path through the loop can leave a value unassigned and infer a latch.
  always_comb begin
    w_carry = i_cin;
    w_fa    = '0;
    o_sum   = '0;
    o_cmsb  = 1'b0;
    // NOTE: blocking assignments are required here -- w_carry must ripple from
    // one loop iteration to the next within a single evaluation.
    for (int i = 0; i < WS; i++) begin
      o_cmsb   = w_carry;      // after the last iteration: carry into the MSB
      w_fa     = full_adder(i_a[i], i_b[i], w_carry);
      o_sum[i] = w_fa.sum;
      w_carry  = w_fa.cout;
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//   S-stage pipelined ripple adder/subtractor with valid/ready handshake.
//   Stage k adds operand segment k; the carry between segments is registered.
//   Operand bits still to be added travel forward in skew registers, finished
//   sum segments travel forward in deskew registers, so every stage holds one
//   transaction and the pipe delivers one result per cycle, latency S.
//   Ports:
//     clk, rstn          clock (rising edge), async active-low reset
//     in_valid/in_ready  operand handshake
//     in_a, in_b   [N]   operands
//     in_cin             carry-in (ignored when in_sub=1)
//     in_sub             1: A - B
//     out_valid/out_ready result handshake
//     out_sum      [N]   result mod 2^N
//     out_cout           carry out of MSB (subtract: 1 = no borrow)
//     out_ovf            signed overflow
// -----------------------------------------------------------------------------
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int N = 16,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int W  = seg_width(N, S);
  localparam int WL = last_width(N, S);

  if (WL < 1) begin : g_bad_split
    $error("pipe_adder: N=%0d cannot be split into S=%0d segments", N, S);
  end

  // Per-stage inputs; index k is what stage k sees this cycle.
  logic [N-1:0] w_a_in   [S];
  logic [N-1:0] w_b_in   [S];
  logic [N-1:0] w_sum_in [S];
  logic [S-1:0] w_vin;
  logic [S-1:0] w_cin;
  logic         w_stall;

  // The whole pipe freezes while a result sits unaccepted at the output.
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // Subtraction is A + ~B + 1, so the forced carry-in rides on in_cin's slot.
  assign w_vin[0]    = in_valid & in_ready;
  assign w_cin[0]    = in_sub | in_cin;
  assign w_a_in[0]   = in_a;
  assign w_b_in[0]   = in_sub ? ~in_b : in_b;
  assign w_sum_in[0] = '0;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int OFF = k * W;
    localparam int WK  = (k == S - 1) ? WL : W;

    logic [WK-1:0] w_seg_sum;
    logic          w_seg_cout;
    logic          w_seg_cmsb;
    logic [N-1:0]  w_sum_nxt;
    stage_ctl_t    r_ctl;
    logic [N-1:0]  r_sum_dsk;

    adder_segment #(.WS(WK)) u_seg (
      .i_a    (w_a_in[k][OFF +: WK]),
      .i_b    (w_b_in[k][OFF +: WK]),
      .i_cin  (w_cin[k]),
      .o_sum  (w_seg_sum),
      .o_cout (w_seg_cout),
      .o_cmsb (w_seg_cmsb)
    );

    // Splice this stage's segment into the partially assembled sum.
    always_comb begin
      w_sum_nxt             = w_sum_in[k];
      w_sum_nxt[OFF +: WK]  = w_seg_sum;
    end

    // NOTE: the datapath registers are reset along with the valid bits so the
    // outputs read zero while in reset; sequential state uses non-blocking
    // assignments so every stage samples its predecessor's old value.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_ctl     <= '0;
        r_sum_dsk <= '0;
      end else if (!w_stall) begin
        r_ctl     <= '{valid: w_vin[k], carry: w_seg_cout};
        r_sum_dsk <= w_sum_nxt;
      end
    end

    if (k < S - 1) begin : g_fwd
      logic [N-1:0] r_a_skew;
      logic [N-1:0] r_b_skew;
      logic         w_unused_cmsb;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_a_skew <= '0;
          r_b_skew <= '0;
        end else if (!w_stall) begin
          r_a_skew <= w_a_in[k];
          r_b_skew <= w_b_in[k];
        end
      end

      assign w_a_in[k+1]   = r_a_skew;
      assign w_b_in[k+1]   = r_b_skew;
      assign w_sum_in[k+1] = r_sum_dsk;
      assign w_vin[k+1]    = r_ctl.valid;
      assign w_cin[k+1]    = r_ctl.carry;
      // Only the MSB segment's internal carry matters for overflow.
      assign w_unused_cmsb = w_seg_cmsb;
    end else begin : g_last
      logic r_ovf;
      logic w_unused_ops;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_ovf <= 1'b0;
        end else if (!w_stall) begin
          r_ovf <= w_seg_cmsb ^ w_seg_cout;
        end
      end

      assign out_valid = r_ctl.valid;
      assign out_cout  = r_ctl.carry;
      assign out_sum   = r_sum_dsk;
      assign out_ovf   = r_ovf;
      // Operand bits below the last segment were consumed by earlier stages.
      assign w_unused_ops = ^{w_a_in[k], w_b_in[k]};
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
//   Directed and random checks of pipe_adder in the default N=16,S=4 shape,
//   plus N=10/S=4, N=16/S=1 and N=4/S=4 instances driven from a shared bus.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

  localparam int N = 16;
  localparam int S = 4;
  localparam int XN [3] = '{10, 16, 4};
  localparam int XS [3] = '{4, 1, 4};

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  // Hand-computed directed vectors for the 16-bit instance.
  localparam vec_t VECS [8] = '{
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}},
    '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}},
    '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}},
    '{16'h00FF, 16'h0001, 1'b1, 1'b0, '{16'h0101, 1'b0, 1'b0}},
    '{16'h0FFF, 16'hF000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0}},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}}
  };

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Main 16/4 instance
  logic         in_valid, in_ready, in_cin, in_sub;
  logic [N-1:0] in_a, in_b, out_sum;
  logic         out_valid, out_ready, out_cout, out_ovf;

  pipe_adder #(.N(16), .S(4)) u_dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // Extra configurations sharing one stimulus bus (low N bits each)
  logic        x_valid, x_cin, x_sub;
  logic [15:0] x_a, x_b;
  logic [2:0]  xr, xv, xc, xo;
  logic [9:0]  s10;
  logic [15:0] s16;
  logic [3:0]  s4;
  logic [15:0] xs [3];

  assign xs[0] = {6'd0, s10};
  assign xs[1] = s16;
  assign xs[2] = {12'd0, s4};

  pipe_adder #(.N(10), .S(4)) u_n10 (
    .clk(clk), .rstn(rstn), .in_valid(x_valid), .in_ready(xr[0]),
    .in_a(x_a[9:0]), .in_b(x_b[9:0]), .in_cin(x_cin), .in_sub(x_sub),
    .out_valid(xv[0]), .out_ready(1'b1), .out_sum(s10), .out_cout(xc[0]), .out_ovf(xo[0])
  );

  pipe_adder #(.N(16), .S(1)) u_s1 (
    .clk(clk), .rstn(rstn), .in_valid(x_valid), .in_ready(xr[1]),
    .in_a(x_a), .in_b(x_b), .in_cin(x_cin), .in_sub(x_sub),
    .out_valid(xv[1]), .out_ready(1'b1), .out_sum(s16), .out_cout(xc[1]), .out_ovf(xo[1])
  );

  pipe_adder #(.N(4), .S(4)) u_n4 (
    .clk(clk), .rstn(rstn), .in_valid(x_valid), .in_ready(xr[2]),
    .in_a(x_a[3:0]), .in_b(x_b[3:0]), .in_cin(x_cin), .in_sub(x_sub),
    .out_valid(xv[2]), .out_ready(1'b1), .out_sum(s4), .out_cout(xc[2]), .out_ovf(xo[2])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Golden model: plain integer add, overflow from operand/result signs.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input int n);
    res_t        r;
    logic [15:0] mask, aa, bb;
    logic [16:0] t;
    mask  = 16'hFFFF >> (16 - n);
    aa    = a & mask;
    bb    = (sub ? ~b : b) & mask;
    t     = {1'b0, aa} + {1'b0, bb} + {16'd0, (sub | cin)};
    r.sum  = t[15:0] & mask;
    r.cout = t[n];
    r.ovf  = (aa[n-1] == bb[n-1]) && (r.sum[n-1] != aa[n-1]);
    return r;
  endfunction

  task automatic test_reset;
    rstn = 1'b0;
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b1; in_sub = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b want=1", in_ready); end
    n_cmp++;
    if ({out_sum, out_cout, out_ovf} !== 18'd0)
      begin n_bad++; $display("FAIL rst_data got=%h/%b/%b want=0000/0/0", out_sum, out_cout, out_ovf); end
    rstn = 1'b1;
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_release_idle k=%0d got=%b want=0", k, out_valid); end
    end
  endtask

  task automatic test_add_sub;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = VECS[v].a; in_b = VECS[v].b; in_cin = VECS[v].cin; in_sub = VECS[v].sub;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (S - 2) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vec%0d_early got=%b want=0", v, out_valid); end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL vec%0d_latency got=%b want=1", v, out_valid); end
      n_cmp++;
      if ({out_sum, out_cout, out_ovf} !== VECS[v].exp)
        begin n_bad++; $display("FAIL vec%0d_result got=%h/%b/%b want=%h/%b/%b", v, out_sum, out_cout, out_ovf,
                                VECS[v].exp.sum, VECS[v].exp.cout, VECS[v].exp.ovf); end
    end
  endtask

  // Streams n_ops random operations; out_ready drops for stall_len cycles
  // starting at cycle stall_at. Results are scoreboarded in order.
  task automatic run_stream(input string name, input int n_ops, input int stall_at, input int stall_len);
    res_t        exp_q[$];
    res_t        e;
    logic [15:0] a, b;
    logic        cin, sub;
    int          sent, got, cyc, first_cyc, last_cyc;
    sent = 0; got = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    while (got < n_ops && cyc < 200) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = (sent < n_ops);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub;
      #1;
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_stall_ready cyc=%0d got=%b want=0", name, cyc, in_ready); end
        if (exp_q.size() > 0) begin
          n_cmp++;
          if ({out_sum, out_cout, out_ovf} !== exp_q[0])
            begin n_bad++; $display("FAIL %s_stall_hold cyc=%0d got=%h/%b/%b want=%h/%b/%b", name, cyc,
                                    out_sum, out_cout, out_ovf, exp_q[0].sum, exp_q[0].cout, exp_q[0].ovf); end
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL %s_extra cyc=%0d got=%h want=no result", name, cyc, out_sum);
        end else begin
          e = exp_q.pop_front();
          if ({out_sum, out_cout, out_ovf} !== e)
            begin n_bad++; $display("FAIL %s_result#%0d got=%h/%b/%b want=%h/%b/%b", name, got,
                                    out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf); end
        end
        got++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub, 16));
        sent++;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got != n_ops) begin n_bad++; $display("FAIL %s_count got=%0d want=%0d", name, got, n_ops); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_dup got=%b want=0", name, out_valid); end
    if (stall_len == 0) begin
      n_cmp++;
      if (last_cyc - first_cyc != n_ops - 1)
        begin n_bad++; $display("FAIL %s_throughput span=%0d want=%0d", name, last_cyc - first_cyc, n_ops - 1); end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'h0101 << i; in_b = 16'h0011; in_cin = 1'b0; in_sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got=%b want=1", out_valid); end
    #1 rstn = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_bad++; $display("FAIL rstmid_async got=%b/%b want=0/1", out_valid, in_ready); end
    @(negedge clk);
    // Release and offer a new operand on the same cycle: it must be taken on
    // the first edge and be the only thing that comes out.
    rstn = 1'b1;
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h1111; in_cin = 1'b0; in_sub = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== (k == S)) begin n_bad++; $display("FAIL rstmid_valid k=%0d got=%b want=%b", k, out_valid, (k == S)); end
      if (k == S) begin
        n_cmp++;
        if ({out_sum, out_cout, out_ovf} !== {16'h2345, 1'b0, 1'b0})
          begin n_bad++; $display("FAIL rstmid_first got=%h/%b/%b want=2345/0/0", out_sum, out_cout, out_ovf); end
      end
    end
  endtask

  task automatic test_configs;
    res_t e;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      x_valid = 1'b1;
      if (i == 0) begin
        x_a = 16'h03FF; x_b = 16'h0001; x_cin = 1'b0; x_sub = 1'b0;
      end else if (i == 1) begin
        x_a = 16'h0005; x_b = 16'h0007; x_cin = 1'b1; x_sub = 1'b1;
      end else begin
        x_a = 16'($urandom); x_b = 16'($urandom); x_cin = 1'($urandom); x_sub = 1'($urandom);
      end
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (k == 1) x_valid = 1'b0;
        n_cmp++;
        if (xr !== 3'b111) begin n_bad++; $display("FAIL cfg_ready op=%0d got=%b want=111", i, xr); end
        for (int j = 0; j < 3; j++) begin
          e = model(x_a, x_b, x_cin, x_sub, XN[j]);
          n_cmp++;
          if (xv[j] !== (k == XS[j]))
            begin n_bad++; $display("FAIL cfg%0d_valid op=%0d k=%0d got=%b want=%b", j, i, k, xv[j], (k == XS[j])); end
          if (k == XS[j]) begin
            n_cmp++;
            if ({xs[j], xc[j], xo[j]} !== e)
              begin n_bad++; $display("FAIL cfg%0d_result op=%0d got=%h/%b/%b want=%h/%b/%b", j, i,
                                      xs[j], xc[j], xo[j], e.sum, e.cout, e.ovf); end
            if (i == 0 && j == 0) begin
              n_cmp++;
              if ({xs[0], xc[0]} !== {16'h0000, 1'b1})
                begin n_bad++; $display("FAIL n10_3ff_plus_1 got=%h/%b want=000/1", xs[0], xc[0]); end
            end
          end
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    x_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0;
    test_reset();
    test_add_sub();
    run_stream("b2b", 20, 0, 0);
    run_stream("bp", 12, 6, 3);
    test_reset_mid();
    test_configs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
